// File: rtl/key_mem_ctrl.sv
// Key-driven byte memory controller: sequences write, read and clear-all operations
// on an internal array. Optional macro KEY_MEM_AUTOINC_EN advances addr after WRITE/READ.
module key_mem_ctrl #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_wr,
    input  logic          cmd_rd,
    input  logic          cmd_clr,
    input  logic          cmd_addr,
    input  logic [DW-1:0] sw,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

`ifdef KEY_MEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [AW-1:0] LAST_LOC = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          done_q, done_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sweep_d   = sweep_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                // Only the highest-priority command acts; the rest are dropped.
                if (cmd_clr) begin
                    state_d = CLEAR;
                    rdata_d = '0;
                    sweep_d = '0;
                end else if (cmd_addr) begin
                    addr_d = sw[AW-1:0];
                end else if (cmd_wr) begin
                    wdata_d = sw;
                    state_d = WRITE;
                end else if (cmd_rd) begin
                    state_d = READ;
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                state_d = IDLE;
                done_d  = 1'b1;
                if (AUTOINC) addr_d = addr_q + AW'(1);
            end
            READ: begin
                rdata_d = mem[addr_q];
                state_d = IDLE;
                done_d  = 1'b1;
                if (AUTOINC) addr_d = addr_q + AW'(1);
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + AW'(1);
                if (sweep_q == LAST_LOC) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage is never reset; a reset edge only suppresses the pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sweep_q <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sweep_q <= sweep_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign addr  = addr_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule
